// File: rtl/gfx_pkg.sv
// Shared graphics types: coordinate type, line rasteriser state encoding and
// default screen dimensions.
package gfx_pkg;
  localparam int COORD_W_DEF  = 10;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW
  } line_state_e;
endpackage

// File: rtl/line_raster_if.sv
// Command (endpoint start/ready) and pixel (valid/ready) stream bundle for
// the line rasteriser; master is the command/pixel consumer side.
interface line_raster_if #(
  parameter int COORD_W = gfx_pkg::COORD_W_DEF
);
  logic               start;
  logic               start_ready;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_last;
  logic               busy;
  logic               done;

  modport master (
    output start, x0, y0, x1, y1, pix_ready,
    input  start_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, pix_ready,
    output start_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
  );
endinterface

// File: rtl/line_step.sv
// Combinational Bresenham step: one error update and x/y advance.
// sx/sy are direction flags: 1 steps by -1, 0 steps by +1.
module line_step #(
  parameter  int COORD_W = 10,
  localparam int W       = COORD_W + 2
) (
  input  logic signed [W-1:0]  err,
  input  logic signed [W-1:0]  dx,
  input  logic signed [W-1:0]  dy,
  input  logic                 sx,
  input  logic                 sy,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  output logic signed [W-1:0]  err_nxt,
  output logic [COORD_W-1:0]   x_nxt,
  output logic [COORD_W-1:0]   y_nxt
);
  localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  // e2 needs one extra bit so 2*err cannot wrap at full-range endpoints
  logic signed [W:0] e2;
  logic signed [W:0] dx_e;
  logic signed [W:0] dy_e;

  always_comb begin
    e2      = {err, 1'b0};
    dx_e    = {dx[W-1], dx};
    dy_e    = {dy[W-1], dy};
    err_nxt = err;
    x_nxt   = x;
    y_nxt   = y;
    if (e2 >= dy_e) begin
      err_nxt = err_nxt + dy;
      x_nxt   = sx ? (x - ONE) : (x + ONE);
    end
    if (e2 <= dx_e) begin
      err_nxt = err_nxt + dx;
      y_nxt   = sy ? (y - ONE) : (y + ONE);
    end
  end
endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: endpoints in via start/ready, one pixel per clock
// out via valid/ready. Define LINE_RASTER_CLIP_EN to drop off-screen pixels.
module line_raster
  import gfx_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  line_raster_if.slave  bus
);
  localparam int W = COORD_W + 2;

  function automatic logic signed [W-1:0] abs_s(input logic signed [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  line_state_e         state, state_nxt;
  logic [COORD_W-1:0]  x0_r, y0_r, x1_r, y1_r;
  logic [COORD_W-1:0]  x_r, y_r, x_nxt, y_nxt;
  logic signed [W-1:0] dx_r, dy_r, err_r, err_nxt;
  logic signed [W-1:0] dx_d, dy_d;
  logic                sx_r, sy_r, done_r;
  logic                at_end, visible, step;

  assign dx_d   = abs_s($signed({2'b00, x1_r}) - $signed({2'b00, x0_r}));
  assign dy_d   = -abs_s($signed({2'b00, y1_r}) - $signed({2'b00, y0_r}));
  assign at_end = (x_r == x1_r) && (y_r == y1_r);

`ifdef LINE_RASTER_CLIP_EN
  localparam logic [COORD_W:0] SW = SCREEN_W[COORD_W:0];
  localparam logic [COORD_W:0] SH = SCREEN_H[COORD_W:0];
  assign visible = ({1'b0, x_r} < SW) && ({1'b0, y_r} < SH);
`else
  assign visible = 1'b1;
`endif

  // Off-screen pixels advance without waiting for the consumer
  assign step = (state == DRAW) && (bus.pix_ready || !visible);

  line_step #(.COORD_W(COORD_W)) u_step (
    .err     (err_r),
    .dx      (dx_r),
    .dy      (dy_r),
    .sx      (sx_r),
    .sy      (sy_r),
    .x       (x_r),
    .y       (y_r),
    .err_nxt (err_nxt),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETUP;
      SETUP:   state_nxt = DRAW;
      DRAW:    if (step && at_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r <= '0; y0_r <= '0; x1_r <= '0; y1_r <= '0;
      x_r  <= '0; y_r  <= '0;
      dx_r <= '0; dy_r <= '0; err_r <= '0;
      sx_r <= 1'b0; sy_r <= 1'b0; done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          x0_r <= bus.x0; y0_r <= bus.y0;
          x1_r <= bus.x1; y1_r <= bus.y1;
          x_r  <= bus.x0; y_r  <= bus.y0;
        end
        SETUP: begin
          dx_r  <= dx_d;
          dy_r  <= dy_d;
          err_r <= dx_d + dy_d;
          sx_r  <= !(x0_r < x1_r);
          sy_r  <= !(y0_r < y1_r);
        end
        DRAW: if (step) begin
          if (at_end) begin
            done_r <= 1'b1;
          end else begin
            err_r <= err_nxt;
            x_r   <= x_nxt;
            y_r   <= y_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.pix_valid   = (state == DRAW) && visible;
  assign bus.pix_last    = (state == DRAW) && visible && at_end;
  assign bus.pix_x       = x_r;
  assign bus.pix_y       = y_r;
  assign bus.done        = done_r;
endmodule

// File: doc/line_raster.md
Name: line_raster

Overview:
- Parametrised Bresenham line rasteriser for the graphics pipeline.
- Accepts two endpoints through a start/ready handshake and handles all eight octants, including lines drawn right-to-left and bottom-to-top.
- Emits one pixel coordinate per clock on a valid/ready stream with backpressure.
- Sits between the command decoder and the framebuffer write arbiter.

Parameters:
- COORD_W, 10: width of each unsigned x/y coordinate.
- SCREEN_W, 640: visible width in pixels; used only when clipping is compiled in.
- SCREEN_H, 480: visible height in pixels; used only when clipping is compiled in.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to draw a line; x0/y0/x1/y1 are sampled when start && start_ready.
- start_ready  out  1  high when IDLE and able to accept a line.
- x0  in  COORD_W  first endpoint x.
- y0  in  COORD_W  first endpoint y.
- x1  in  COORD_W  second endpoint x.
- y1  in  COORD_W  second endpoint y.
- pix_valid  out  1  pix_x/pix_y hold a pixel.
- pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready.
- pix_x  out  COORD_W  pixel x.
- pix_y  out  COORD_W  pixel y.
- pix_last  out  1  marks the x1,y1 endpoint pixel.
- busy  out  1  high whenever the block is not IDLE.
- done  out  1  one-cycle pulse when the line is finished.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, start_ready=1, pix_valid=0, pix_last=0, busy=0, done=0, pix_x=0, pix_y=0. Internal registers are cleared to 0.
- Reset mid-line: asserting rst_n low abandons the line immediately. No done pulse is produced.
- FSM states: IDLE, SETUP, DRAW.
- IDLE to SETUP on the start handshake. Endpoints are latched; start_ready drops the following cycle.
- SETUP (exactly 1 cycle) computes, in signed COORD_W+2 arithmetic:
  - dx = |x1-x0|, dy = -|y1-y0|, err = dx+dy;
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1;
  - current position = (x0, y0).
- First pix_valid appears 2 cycles after the start handshake edge.
- DRAW:
  - pix_valid=1 and pix_x/pix_y show the current position.
  - pix_last=1 when current == (x1, y1).
  - On a pixel handshake with current != end: e2 = 2*err.
    - If e2 >= dy: err += dy, x += sx.
    - If e2 <= dx: err += dx, y += sy. Both steps may apply in the same cycle.
    - The next pixel is presented the following cycle, giving a throughput of 1 pixel/clk while pix_ready is held high.
  - On a pixel handshake with current == end: go to IDLE, pulse done for 1 cycle, clear pix_valid. start_ready returns high that same cycle.
- Backpressure: while pix_valid && !pix_ready, pix_x, pix_y, pix_last and all internal state hold stable.
- Pixel count: exactly max(|x1-x0|, |y1-y0|)+1 pixels. A degenerate line (x0==x1 and y0==y1) emits one pixel with pix_last=1.
- Start during SETUP or DRAW is ignored (start_ready=0). Endpoint input changes after the handshake have no effect.
- Internal arithmetic never overflows for any COORD_W-bit endpoints. Emitted coordinates always lie within [min, max] of the two endpoints.

Optional Feature:
- Macro: LINE_RASTER_CLIP_EN.
- Defined:
  - Pixels with x >= SCREEN_W or y >= SCREEN_H are stepped internally at 1 per cycle with pix_valid=0; they are never emitted.
  - If the endpoint pixel is clipped, pix_last is never seen; done still pulses once the endpoint step completes.
- Undefined:
  - Every pixel is emitted. SCREEN_W and SCREEN_H are unused.

Decomposition:
- Shared package gfx_pkg holds:
  - coord_t (COORD_W-bit unsigned);
  - the line_state_e enum {IDLE, SETUP, DRAW};
  - the default SCREEN_W and SCREEN_H constants.
- One natural sub-module: line_step, a combinational Bresenham step. Inputs err, dx, dy, sx, sy, x, y; outputs next err, x, y. It is instantiated once by the FSM wrapper.

Test Plan:
- Horizontal line: start with (0,0)->(3,0), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, pix_last on (3,0), done 1 cycle after.
- Steep reverse line: (2,5)->(0,0) -> pixels exactly (2,5),(2,4),(1,3),(1,2),(0,1),(0,0).
- Degenerate line: (5,5)->(5,5) -> single pixel (5,5) with pix_last=1, then done. First pix_valid is 2 cycles after start.
- Backpressure and ignored start:
  - During (0,0)->(3,0), drop pix_ready for 3 cycles at (1,0) -> outputs held stable, no pixel lost or duplicated.
  - start pulsed while busy -> ignored.
- Reset mid-line: rst_n low during pixel 2 of (0,0)->(9,9) -> all outputs at reset values immediately, no done pulse. A new start afterwards draws correctly from its own x0,y0.
- Clipping (LINE_RASTER_CLIP_EN, SCREEN_W=4): (2,0)->(5,0) -> only (2,0),(3,0) emitted, no pix_last, done pulses 2 cycles after the (3,0) handshake.
